key_debounce: RTL

//  Input-side counterpart of the board LED drivers: synchronises and debounces N push-buttons.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_debounce_ch.sv | 120 ++++++++++++
 rtl/key_debounce.sv | 50 +++++
 3 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and counter sizing for the key debouncer
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } key_fsm_e;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: two-flop synchroniser, debounce FSM, long-press timer
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic level,
    output logic press_strobe,
    output logic release_strobe,
    output logic long_strobe,
    output logic press_next
);

    localparam int            CW        = cnt_width(LONG_CYC);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] HOLD_FIRE = CW'(LONG_CYC - 2);

    logic          sync1_q, sync2_q;
    key_fsm_e      state_q, state_n;
    logic [CW-1:0] db_q, db_n;
    logic [CW-1:0] hold_q, hold_n;
    logic          done_q, done_n;
    logic          level_n, rel_n, long_n;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            state_q        <= ST_IDLE;
            db_q           <= '0;
            hold_q         <= '0;
            done_q         <= 1'b0;
            level          <= 1'b0;
            press_strobe   <= 1'b0;
            release_strobe <= 1'b0;
            long_strobe    <= 1'b0;
        end else begin
            sync1_q        <= key_raw;
            sync2_q        <= sync1_q;
            state_q        <= state_n;
            db_q           <= db_n;
            hold_q         <= hold_n;
            done_q         <= done_n;
            level          <= level_n;
            press_strobe   <= press_next;
            release_strobe <= rel_n;
            long_strobe    <= long_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        db_n       = db_q;
        hold_n     = hold_q;
        done_n     = done_q;
        level_n    = level;
        press_next = 1'b0;
        rel_n      = 1'b0;
        long_n     = 1'b0;

        // Hold timer keeps running through a release glitch so long-press timing is not reset
        if (state_q == ST_HELD || state_q == ST_REL_DB) begin
            if (hold_q != HOLD_LAST) begin
                hold_n = hold_q + 1'b1;
                if (hold_q == HOLD_FIRE && !done_q) begin
                    long_n = 1'b1;
                    done_n = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_n = ST_PRESS_DB;
                    db_n    = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!sync2_q) begin
                    state_n = ST_IDLE;
                end else if (db_q == DB_LAST) begin
                    state_n    = ST_HELD;
                    press_next = 1'b1;
                    level_n    = 1'b1;
                    hold_n     = '0;
                    done_n     = 1'b0;
                end else begin
                    db_n = db_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_n = ST_REL_DB;
                    db_n    = '0;
                end
            end
            ST_REL_DB: begin
                if (sync2_q) begin
                    state_n = ST_HELD;
                end else if (db_q == DB_LAST) begin
                    // An accepted release takes priority over a coincident long-press
                    state_n = ST_IDLE;
                    rel_n   = 1'b1;
                    level_n = 1'b0;
                    long_n  = 1'b0;
                end else begin
                    db_n = db_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - N-key debouncer top: pin polarity mapping, per-key channels, key_any
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                key_any
);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] press_next;

    assign key_raw = ACTIVE_LOW ? ~key_in : key_in;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .sys_clk        (sys_clk),
            .sys_rst_n      (sys_rst_n),
            .key_raw        (key_raw[k]),
            .level          (key_state[k]),
            .press_strobe   (key_press[k]),
            .release_strobe (key_release[k]),
            .long_strobe    (key_long[k]),
            .press_next     (press_next[k])
        );
    end

    // Registered from the same next-cycle press terms so it aligns with key_press
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            key_any <= 1'b0;
        end else begin
            key_any <= |press_next;
        end
    end

endmodule
